// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared helpers for pipelined blocks
package pipe_pkg;

  // Occupancy counter width for a pipe of `stage` slices (at least 1 bit)
  function automatic int cnt_w(input int stage);
    return (stage < 1) ? 1 : $clog2(stage + 1);
  endfunction

endpackage

// File: rtl/pipe_slice.sv
// rtl/pipe_slice.sv - one elastic register slice holding a valid bit and payload
module pipe_slice #(
  parameter int WIDTH      = 8,
  parameter bit RESET_DATA = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             rdy_nxt,
  output logic             v,
  output logic [WIDTH-1:0] d,
  output logic             rdy
);

  // An empty slice always absorbs upstream data, so bubbles collapse under stall
  assign rdy = ~v | rdy_nxt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v <= 1'b0;
    end else if (rdy) begin
      v <= v_in;
    end
  end

  // Payload only loads on a real token; bubbles leave the old data in place
  always_ff @(posedge clk) begin
    if (rst) begin
      if (RESET_DATA) begin
        d <= '0;
      end
    end else if (!flush && rdy && v_in) begin
      d <= d_in;
    end
  end

endmodule

// File: rtl/elastic_shift_pipe.sv
// rtl/elastic_shift_pipe.sv - elastic valid/ready delay line with flush and occupancy count
module elastic_shift_pipe
  import pipe_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STAGE      = 0,
  parameter bit RESET_DATA = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(STAGE)-1:0]   count
);

  localparam int CW = cnt_w(STAGE);

  generate
    if (STAGE == 0) begin : g_wire
      // No state: clock and reset are intentionally left unused here
      logic unused_seq;
      assign unused_seq = clk ^ rst;

      assign out_valid = in_valid & ~flush;
      assign in_ready  = out_ready & ~flush;
      assign out_data  = in_data;
      assign count     = {CW{1'b0}};
    end else begin : g_pipe
      logic [STAGE:0]     v;
      logic [WIDTH-1:0]   d [0:STAGE];
      logic [STAGE+1:1]   rdy;
      logic               in_xfer;
      logic               out_xfer;

      assign v[0]         = in_valid;
      assign d[0]         = in_data;
      assign rdy[STAGE+1] = out_ready & ~flush;

      for (genvar k = 1; k <= STAGE; k++) begin : g_stage
        pipe_slice #(
          .WIDTH      (WIDTH),
          .RESET_DATA (RESET_DATA)
        ) u_slice (
          .clk     (clk),
          .rst     (rst),
          .flush   (flush),
          .v_in    (v[k-1]),
          .d_in    (d[k-1]),
          .rdy_nxt (rdy[k+1]),
          .v       (v[k]),
          .d       (d[k]),
          .rdy     (rdy[k])
        );
      end

      assign in_ready  = rdy[1] & ~flush;
      assign out_valid = v[STAGE] & ~flush;
      assign out_data  = d[STAGE];

      assign in_xfer  = in_valid & in_ready;
      assign out_xfer = out_valid & out_ready;

      // Tokens are conserved inside the pipe, so occupancy tracks port transfers
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          count <= '0;
        end else begin
          count <= count + CW'(in_xfer) - CW'(out_xfer);
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_elastic_shift_pipe.sv
// tb/tb_elastic_shift_pipe.sv - directed and random checks of elastic_shift_pipe
module tb_elastic_shift_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // STAGE=3, data reset
  logic       a_rst, a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_count;

  // STAGE=0 pass-through
  logic       z_rst, z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [7:0] z_in_data, z_out_data;
  logic [0:0] z_count;

  // STAGE=4, data not reset
  logic       r_rst, r_flush, r_in_valid, r_in_ready, r_out_valid, r_out_ready;
  logic [7:0] r_in_data, r_out_data;
  logic [2:0] r_count;

  elastic_shift_pipe #(.WIDTH(8), .STAGE(3), .RESET_DATA(1'b1)) u_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .count(a_count)
  );

  elastic_shift_pipe #(.WIDTH(8), .STAGE(0), .RESET_DATA(1'b0)) u_z (
    .clk(clk), .rst(z_rst), .flush(z_flush),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
    .count(z_count)
  );

  elastic_shift_pipe #(.WIDTH(8), .STAGE(4), .RESET_DATA(1'b0)) u_r (
    .clk(clk), .rst(r_rst), .flush(r_flush),
    .in_valid(r_in_valid), .in_ready(r_in_ready), .in_data(r_in_data),
    .out_valid(r_out_valid), .out_ready(r_out_ready), .out_data(r_out_data),
    .count(r_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_rst = 1'b1;
    tick;
    tick;
    a_rst = 1'b0;
    #1;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", a_out_valid); end
    total++; if (a_out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h exp=00", a_out_data); end
    total++; if (a_count !== 2'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", a_in_ready); end
  endtask

  task automatic test_latency;
    int         exp_cnt [7];
    logic [7:0] exp_d;
    exp_cnt = '{0, 1, 2, 3, 2, 1, 0};
    a_out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_in_valid = (i < 3);
      a_in_data  = 8'(8'h11 * (i + 1));
      #1;
      total++; if (a_count !== 2'(exp_cnt[i])) begin bad++; $display("FAIL lat_count[%0d] got=%0d exp=%0d", i, a_count, exp_cnt[i]); end
      total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL lat_in_ready[%0d] got=%0b exp=1", i, a_in_ready); end
      total++; if (a_out_valid !== (i >= 3 && i <= 5)) begin bad++; $display("FAIL lat_out_valid[%0d] got=%0b", i, a_out_valid); end
      if (i >= 3 && i <= 5) begin
        exp_d = 8'(8'h11 * (i - 2));
        total++; if (a_out_data !== exp_d) begin bad++; $display("FAIL lat_out_data[%0d] got=%h exp=%h", i, a_out_data, exp_d); end
      end
      tick;
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [7:0] exp_d;
    a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(8'hA0 + i);
      #1;
      total++; if (a_in_ready !== (i < 3)) begin bad++; $display("FAIL bp_in_ready[%0d] got=%0b exp=%0b", i, a_in_ready, (i < 3)); end
      if (i == 3) begin
        total++; if (a_count !== 2'd3) begin bad++; $display("FAIL bp_count got=%0d exp=3", a_count); end
      end
      tick;
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (a_out_valid !== (i < 3)) begin bad++; $display("FAIL bp_out_valid[%0d] got=%0b exp=%0b", i, a_out_valid, (i < 3)); end
      if (i < 3) begin
        exp_d = 8'(8'hA0 + i);
        total++; if (a_out_data !== exp_d) begin bad++; $display("FAIL bp_out_data[%0d] got=%h exp=%h", i, a_out_data, exp_d); end
      end
      tick;
    end
  endtask

  task automatic test_bubble;
    a_out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = (i == 0 || i == 3);
      a_in_data  = (i == 0) ? 8'h01 : 8'h02;
      #1;
      total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bub_in_ready[%0d] got=%0b exp=1", i, a_in_ready); end
      tick;
    end
    a_in_valid = 1'b0;
    #1;
    total++; if (a_count !== 2'd2) begin bad++; $display("FAIL bub_count got=%0d exp=2", a_count); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL bub_held_in_ready got=%0b exp=1", a_in_ready); end
    total++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h01) begin bad++; $display("FAIL bub_head got=%0b/%h exp=1/01", a_out_valid, a_out_data); end
    a_out_ready = 1'b1;
    tick;
    total++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h02) begin bad++; $display("FAIL bub_second got=%0b/%h exp=1/02", a_out_valid, a_out_data); end
    tick;
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL bub_empty got=%0b exp=0", a_out_valid); end
    tick;
  endtask

  task automatic test_flush;
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(8'hB1 + i);
      tick;
    end
    a_flush    = 1'b1;
    a_in_data  = 8'hFF;
    #1;
    total++; if (a_count !== 2'd3) begin bad++; $display("FAIL fl_pre_count got=%0d exp=3", a_count); end
    total++; if (a_in_ready !== 1'b0) begin bad++; $display("FAIL fl_in_ready got=%0b exp=0", a_in_ready); end
    total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL fl_out_valid got=%0b exp=0", a_out_valid); end
    tick;
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    #1;
    total++; if (a_count !== 2'd0) begin bad++; $display("FAIL fl_count got=%0d exp=0", a_count); end
    total++; if (a_in_ready !== 1'b1) begin bad++; $display("FAIL fl_post_in_ready got=%0b exp=1", a_in_ready); end
    a_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (a_out_valid !== 1'b0) begin bad++; $display("FAIL fl_leak[%0d] got=%0b/%h exp=0", i, a_out_valid, a_out_data); end
      tick;
    end
  endtask

  task automatic test_stage0;
    logic [10:0] vec [4];
    logic        iv, orr, fl;
    vec = '{{1'b1, 1'b1, 1'b0, 8'h5A}, {1'b0, 1'b1, 1'b0, 8'hC3},
            {1'b1, 1'b0, 1'b0, 8'hFF}, {1'b1, 1'b1, 1'b1, 8'h00}};
    for (int i = 0; i < 4; i++) begin
      iv  = vec[i][10];
      orr = vec[i][9];
      fl  = vec[i][8];
      z_in_valid  = iv;
      z_out_ready = orr;
      z_flush     = fl;
      z_in_data   = vec[i][7:0];
      #1;
      total++; if (z_out_data !== vec[i][7:0]) begin bad++; $display("FAIL s0_data[%0d] got=%h exp=%h", i, z_out_data, vec[i][7:0]); end
      total++; if (z_out_valid !== (iv & ~fl)) begin bad++; $display("FAIL s0_out_valid[%0d] got=%0b exp=%0b", i, z_out_valid, iv & ~fl); end
      total++; if (z_in_ready !== (orr & ~fl)) begin bad++; $display("FAIL s0_in_ready[%0d] got=%0b exp=%0b", i, z_in_ready, orr & ~fl); end
      total++; if (z_count !== 1'b0) begin bad++; $display("FAIL s0_count[%0d] got=%0d exp=0", i, z_count); end
    end
  endtask

  task automatic test_random;
    logic [7:0] q [$];
    logic       exp_ir;
    r_rst = 1'b1;
    tick;
    tick;
    r_rst = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      r_in_valid  = 1'($urandom_range(0, 1));
      r_out_ready = ($urandom_range(0, 3) != 0);
      r_flush     = ($urandom_range(0, 99) == 0);
      r_in_data   = 8'($urandom);
      #1;
      total++; if (r_count !== 3'(q.size())) begin bad++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", i, r_count, q.size()); end
      exp_ir = !r_flush && (q.size() < 4 || r_out_ready);
      total++; if (r_in_ready !== exp_ir) begin bad++; $display("FAIL rnd_in_ready[%0d] got=%0b exp=%0b", i, r_in_ready, exp_ir); end
      if (r_out_valid && r_out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rnd_spurious[%0d] got=%h exp=empty", i, r_out_data);
        end else begin
          if (r_out_data !== q[0]) begin bad++; $display("FAIL rnd_order[%0d] got=%h exp=%h", i, r_out_data, q[0]); end
          void'(q.pop_front());
        end
      end
      if (r_in_valid && r_in_ready) q.push_back(r_in_data);
      if (r_flush) q.delete();
      tick;
    end
    r_in_valid = 1'b0;
    r_flush    = 1'b0;
  endtask

  initial begin
    a_rst = 1'b1; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0; a_in_data = 8'h00;
    z_rst = 1'b0; z_flush = 1'b0; z_in_valid = 1'b0; z_out_ready = 1'b0; z_in_data = 8'h00;
    r_rst = 1'b1; r_flush = 1'b0; r_in_valid = 1'b0; r_out_ready = 1'b0; r_in_data = 8'h00;
    test_reset;
    test_latency;
    test_backpressure;
    test_bubble;
    test_flush;
    test_stage0;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
